// File: rtl/hilo_div_ctrl_if.sv
// Request channel between the EX stage and the HI/LO divide controller.
interface hilo_div_ctrl_if;
   logic        div_valid;
   logic        div_signed;
   logic [31:0] div_a;
   logic [31:0] div_b;
   logic        flush;
   logic        req_ready;

   modport master (
      output div_valid, div_signed, div_a, div_b, flush,
      input  req_ready
   );

   modport slave (
      input  div_valid, div_signed, div_a, div_b, flush,
      output req_ready
   );
endinterface

// File: rtl/hilo_div_ctrl.sv
// Sequencing controller for the 32-cycle iterative divider; owns the
// architectural HI/LO registers, MTHI/MTLO writes, flush and div-by-zero.
module hilo_div_ctrl #(
   parameter bit BYPASS_DIV0 = 1'b1
) (
   input  logic                  clk,
   input  logic                  resetn,
   hilo_div_ctrl_if.slave        req,
   input  logic                  hi_we,
   input  logic                  lo_we,
   input  logic [31:0]           hilo_wdata,
   output logic [31:0]           hi,
   output logic [31:0]           lo,
   output logic                  hilo_busy,
   output logic                  done,
   output logic                  dv_start,
   output logic                  dv_sign,
   output logic [31:0]           dv_dividend,
   output logic [31:0]           dv_divider,
   input  logic                  dv_ready,
   input  logic [31:0]           dv_quotient,
   input  logic [31:0]           dv_remainder
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_e;

   state_e      state_q, state_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] dividend_q, dividend_d;
   logic [31:0] divider_q, divider_d;
   logic        sign_q, sign_d;
   logic        start_q, start_d;
   logic        done_q, done_d;

   logic        ready;
   logic        accept;
   logic        div0;
   logic        capture;

   // The divider has no reset, so its dv_ready gates every acceptance.
   assign ready   = (state_q == IDLE) && dv_ready && !req.flush;
   assign accept  = req.div_valid && ready;
   assign div0    = BYPASS_DIV0 && (req.div_b == 32'd0);
   assign capture = (state_q == WAIT) && dv_ready && !req.flush;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         hi_q       <= '0;
         lo_q       <= '0;
         dividend_q <= '0;
         divider_q  <= '0;
         sign_q     <= 1'b0;
         start_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         dividend_q <= dividend_d;
         divider_q  <= divider_d;
         sign_q     <= sign_d;
         start_q    <= start_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept && !div0) state_d = ISSUE;
         end
         ISSUE: begin
            state_d = req.flush ? DRAIN : WAIT;
         end
         WAIT: begin
            if (req.flush)     state_d = DRAIN;
            else if (dv_ready) state_d = IDLE;
         end
         DRAIN: begin
            if (dv_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      hi_d       = hi_q;
      lo_d       = lo_q;
      dividend_d = dividend_q;
      divider_d  = divider_q;
      sign_d     = sign_q;
      start_d    = (state_d == ISSUE);
      done_d     = 1'b0;

      if (!hilo_busy && hi_we) hi_d = hilo_wdata;
      if (!hilo_busy && lo_we) lo_d = hilo_wdata;

      // Operands stay put until the next accept: the divider's sign fix-up
      // of quotient/remainder is combinational on them.
      if (accept) begin
         sign_d     = req.div_signed;
         dividend_d = req.div_a;
         divider_d  = req.div_b;
      end

      if (accept && div0) begin
         hi_d   = req.div_a;
         lo_d   = 32'hFFFF_FFFF;
         done_d = 1'b1;
      end

      if (capture) begin
         lo_d   = dv_quotient;
         hi_d   = dv_remainder;
         done_d = 1'b1;
      end
   end

   assign req.req_ready = ready;
   assign hilo_busy     = (state_q != IDLE);
   assign hi            = hi_q;
   assign lo            = lo_q;
   assign done          = done_q;
   assign dv_start      = start_q;
   assign dv_sign       = sign_q;
   assign dv_dividend   = dividend_q;
   assign dv_divider    = divider_q;

endmodule
